// File: rtl/exec_mdu_pkg.sv
// rtl/exec_mdu_pkg.sv - shared opcode/funct constants, MDU op and FSM state encodings (MDU_MADD_EN adds madd/msub)
package exec_mdu_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  localparam logic [5:0] FN_MADD  = 6'b000000;
  localparam logic [5:0] FN_MADDU = 6'b000001;
  localparam logic [5:0] FN_MSUB  = 6'b000100;
  localparam logic [5:0] FN_MSUBU = 6'b000101;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MTHI  = 4'd6,
    MD_MFLO  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Divides use the divide latency; every other computing op uses the multiply latency
  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/exec_mdu_decode.sv
// rtl/exec_mdu_decode.sv - combinational MDU instruction decode (madd/msub decoded only under MDU_MADD_EN)
module mdu_decode
  import exec_mdu_pkg::*;
(
  input  logic [31:0] i_instr,
  output md_op_e      o_op,
  output logic        o_is_start,
  output logic        o_is_mf,
  output logic        o_is_mt
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic       w_unused_fields;

  assign w_opcode        = i_instr[31:26];
  assign w_funct         = i_instr[5:0];
  assign w_unused_fields = ^i_instr[25:6];

  // Map opcode/funct to an MDU operation, then classify it
  always_comb begin
    o_op = MD_NONE;
    if (w_opcode == OP_SPECIAL) begin
      case (w_funct)
        FN_MULT:  o_op = MD_MULT;
        FN_MULTU: o_op = MD_MULTU;
        FN_DIV:   o_op = MD_DIV;
        FN_DIVU:  o_op = MD_DIVU;
        FN_MFHI:  o_op = MD_MFHI;
        FN_MTHI:  o_op = MD_MTHI;
        FN_MFLO:  o_op = MD_MFLO;
        FN_MTLO:  o_op = MD_MTLO;
        default:  o_op = MD_NONE;
      endcase
    end
`ifdef MDU_MADD_EN
    else if (w_opcode == OP_SPECIAL2) begin
      case (w_funct)
        FN_MADD:  o_op = MD_MADD;
        FN_MADDU: o_op = MD_MADDU;
        FN_MSUB:  o_op = MD_MSUB;
        FN_MSUBU: o_op = MD_MSUBU;
        default:  o_op = MD_NONE;
      endcase
    end
`endif
    o_is_start = (o_op == MD_MULT) || (o_op == MD_MULTU) || (o_op == MD_DIV) ||
                 (o_op == MD_DIVU) || (o_op == MD_MADD) || (o_op == MD_MADDU) ||
                 (o_op == MD_MSUB) || (o_op == MD_MSUBU);
    o_is_mf    = (o_op == MD_MFHI) || (o_op == MD_MFLO);
    o_is_mt    = (o_op == MD_MTHI) || (o_op == MD_MTLO);
  end

endmodule

// File: rtl/exec_mdu.sv
// rtl/exec_mdu.sv - multi-cycle multiply/divide unit with HI/LO registers (MDU_MADD_EN enables madd/msub)
module exec_mdu
  import exec_mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mdD,
  output logic             stall_md,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] md_rdata
);

  localparam int CW = 16;

  md_op_e           w_op;
  logic             w_is_start;
  logic             w_is_mf;
  logic             w_is_mt;

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic             w_start;
  logic             w_done;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_lat;
  md_op_e           r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic signed [2*WIDTH-1:0] w_sa;
  logic signed [2*WIDTH-1:0] w_sb;
  logic [2*WIDTH-1:0]        w_ua;
  logic [2*WIDTH-1:0]        w_ub;
  logic [2*WIDTH-1:0]        w_prod_s;
  logic [2*WIDTH-1:0]        w_prod_u;
  logic [WIDTH-1:0]          w_bd;
  logic [WIDTH-1:0]          w_q_s;
  logic [WIDTH-1:0]          w_r_s;
  logic [WIDTH-1:0]          w_q_u;
  logic [WIDTH-1:0]          w_r_u;
  logic [2*WIDTH-1:0]        w_res;
  logic                      w_res_vld;

  mdu_decode u_decode (
    .i_instr    (instrE),
    .o_op       (w_op),
    .o_is_start (w_is_start),
    .o_is_mf    (w_is_mf),
    .o_is_mt    (w_is_mt)
  );

  assign w_lat = op_is_div(w_op) ? CW'(DIV_LAT) : CW'(MULT_LAT);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: start from IDLE, finish when the counter is on its last cycle
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_start) begin
          w_start     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (r_cnt <= CW'(1)) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch operands and operation on start; count down while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= MD_NONE;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_start) begin
      r_cnt <= w_lat;
      r_op  <= w_op;
      r_a   <= srcaE;
      r_b   <= srcbE;
    end else if (busy) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Result of the latched operation; divide by zero yields no write
  always_comb begin
    w_sa     = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    w_sb     = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    w_ua     = {{WIDTH{1'b0}}, r_a};
    w_ub     = {{WIDTH{1'b0}}, r_b};
    w_prod_s = w_sa * w_sb;
    w_prod_u = w_ua * w_ub;
    // Substitute a divisor of 1 so a zero divisor never produces X in the unused result
    w_bd     = (r_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : r_b;
    w_q_s    = $signed(r_a) / $signed(w_bd);
    w_r_s    = $signed(r_a) % $signed(w_bd);
    w_q_u    = r_a / w_bd;
    w_r_u    = r_a % w_bd;
    w_res     = '0;
    w_res_vld = 1'b0;
    case (r_op)
      MD_MULT:  begin w_res = w_prod_s;     w_res_vld = 1'b1;        end
      MD_MULTU: begin w_res = w_prod_u;     w_res_vld = 1'b1;        end
      MD_DIV:   begin w_res = {w_r_s, w_q_s}; w_res_vld = (r_b != '0); end
      MD_DIVU:  begin w_res = {w_r_u, w_q_u}; w_res_vld = (r_b != '0); end
`ifdef MDU_MADD_EN
      // HI/LO cannot change while busy, so the live registers hold their start-time values
      MD_MADD:  begin w_res = {r_hi, r_lo} + w_prod_s; w_res_vld = 1'b1; end
      MD_MADDU: begin w_res = {r_hi, r_lo} + w_prod_u; w_res_vld = 1'b1; end
      MD_MSUB:  begin w_res = {r_hi, r_lo} - w_prod_s; w_res_vld = 1'b1; end
      MD_MSUBU: begin w_res = {r_hi, r_lo} - w_prod_u; w_res_vld = 1'b1; end
`endif
      default:  begin w_res = '0;           w_res_vld = 1'b0;        end
    endcase
  end

  // HI/LO: computed result on the last busy cycle, mthi/mtlo only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (w_res_vld) begin
        r_hi <= w_res[2*WIDTH-1:WIDTH];
        r_lo <= w_res[WIDTH-1:0];
      end
    end else if ((r_state == ST_IDLE) && w_is_mt) begin
      if (w_op == MD_MTHI) r_hi <= srcaE;
      else                 r_lo <= srcaE;
    end
  end

  // mfhi/mflo read path and hazard stall request
  always_comb begin
    md_rdata = '0;
    if (w_is_mf) md_rdata = (w_op == MD_MFHI) ? r_hi : r_lo;
    stall_md = mdD & (w_start | busy);
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_exec_mdu.sv
// tb/tb_exec_mdu.sv - directed scoreboard bench for exec_mdu
module tb_exec_mdu;

  localparam logic [31:0] NOP   = 32'h0000_0000 | 32'h0000_0025;
  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] MULTU = 32'h0000_0019;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] DIVU  = 32'h0000_001B;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MTHI  = 32'h0000_0011;
  localparam logic [31:0] MFLO  = 32'h0000_0012;
  localparam logic [31:0] MTLO  = 32'h0000_0013;
  localparam logic [31:0] MADD  = 32'h7000_0000;
  localparam logic [31:0] MSUBU = 32'h7000_0005;

  logic        clk;
  logic        reset;
  logic [31:0] instrE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        mdD;
  logic        stall_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  int n_pass;
  int n_total;
  logic [63:0] sb_q[$];

  exec_mdu dut (
    .clk      (clk),
    .reset    (reset),
    .instrE   (instrE),
    .srcaE    (srcaE),
    .srcbE    (srcbE),
    .mdD      (mdD),
    .stall_md (stall_md),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_result(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, " sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " hi"}, {32'd0, hi}, {32'd0, e[63:32]});
      chk({tag, " lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] expv);
    int n;
    sb_q.push_back(expv);
    instrE = instr; srcaE = a; srcbE = b; mdD = 1'b1;
    #1;
    chk({tag, " stall_start"}, {63'd0, stall_md}, 64'd1);
    step();
    instrE = NOP; srcaE = '0; srcbE = '0;
    n = 0;
    while (busy === 1'b1 && n < lat + 5) begin
      if (stall_md !== 1'b1) chk({tag, " stall_busy"}, {63'd0, stall_md}, 64'd1);
      n++;
      step();
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(lat));
    chk({tag, " stall_after"}, {63'd0, stall_md}, 64'd0);
    mdD = 1'b0;
    pop_result(tag);
  endtask

  task automatic mt(input logic [31:0] instr, input logic [31:0] val);
    instrE = instr; srcaE = val; mdD = 1'b0;
    step();
    instrE = NOP; srcaE = '0;
  endtask

  initial begin
    int n;
    n_pass = 0; n_total = 0;
    reset = 1'b1; instrE = NOP; srcaE = '0; srcbE = '0; mdD = 1'b1;
    step(); step();
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst stall", {63'd0, stall_md}, 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    step();

    run_op("mult", MULT, 32'hFFFF_FFFE, 32'd3, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    instrE = MFHI; #1;
    chk("mfhi after mult", {32'd0, md_rdata}, {32'd0, 32'hFFFF_FFFF});
    instrE = NOP; step();

    run_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3, 5, {32'h0000_0002, 32'hFFFF_FFFA});
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu 7/0", DIVU, 32'd7, 32'd0, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 10, {32'h0000_0001, 32'hFFFF_FFFD});
    run_op("divu big", DIVU, 32'hFFFF_FFF9, 32'd2, 10, {32'h0000_0001, 32'h7FFF_FFFC});

    mt(MTHI, 32'h1234_5678);
    chk("mthi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    mt(MTLO, 32'hA5A5_A5A5);
    chk("mtlo", {32'd0, lo}, {32'd0, 32'hA5A5_A5A5});
    instrE = MFLO; #1;
    chk("mflo rdata", {32'd0, md_rdata}, {32'd0, 32'hA5A5_A5A5});
    instrE = NOP; #1;
    chk("nop rdata", {32'd0, md_rdata}, 64'd0);
    step();

    // MDU instruction arriving while busy is ignored; no stall without mdD
    sb_q.push_back({32'd0, 32'd6});
    instrE = MULT; srcaE = 32'd2; srcbE = 32'd3; mdD = 1'b0;
    step();
    instrE = MTHI; srcaE = 32'h0000_DEAD;
    #1;
    chk("stall mdD0", {63'd0, stall_md}, 64'd0);
    step();
    instrE = NOP; srcaE = '0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; step(); end
    chk("ignored busy_done", {63'd0, busy}, 64'd0);
    pop_result("ignored mt");

    // reset in 3rd busy cycle of a divide aborts it
    instrE = DIV; srcaE = 32'd100; srcbE = 32'd7; mdD = 1'b1;
    step();
    instrE = NOP;
    step(); step();
    chk("abort in busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort stall", {63'd0, stall_md}, 64'd0);
    chk("abort hilo", {hi, lo}, 64'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("abort later hilo", {hi, lo}, 64'd0);
    chk("abort later busy", {63'd0, busy}, 64'd0);
    mdD = 1'b0;

`ifdef MDU_MADD_EN
    mt(MTHI, 32'd0);
    mt(MTLO, 32'd5);
    run_op("madd", MADD, 32'd3, 32'd4, 5, {32'd0, 32'd17});
    mt(MTHI, 32'd0);
    mt(MTLO, 32'd5);
    run_op("msubu", MSUBU, 32'd1, 32'd6, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
`else
    mt(MTHI, 32'd0);
    mt(MTLO, 32'd5);
    instrE = MADD; srcaE = 32'd3; srcbE = 32'd4; mdD = 1'b1;
    #1;
    chk("madd noop stall", {63'd0, stall_md}, 64'd0);
    step();
    chk("madd noop busy", {63'd0, busy}, 64'd0);
    instrE = MSUBU; step();
    instrE = NOP; mdD = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("madd noop hilo", {hi, lo}, {32'd0, 32'd5});
`endif

    chk("sb drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
